// File: rtl/box_painter.sv
// Box painter: queues top-left box requests and streams one pixel per cycle
// to a 160x120 VGA adapter, row-major, with off-screen pixels suppressed.
module box_painter #(
    parameter int unsigned BOX_W      = 3,
    parameter int unsigned BOX_H      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_x_i,
    input  logic [6:0] in_y_i,
    input  logic [2:0] in_colour_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic [2:0] colour_o,
    output logic       plot_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LastDx = 4'(BOX_W - 1);
    localparam logic [3:0] LastDy = 4'(BOX_H - 1);

    typedef enum logic [0:0] {StIdle, StDraw} state_e;

    // Request queue, entries packed as {x, y, colour}
    logic [17:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count;
    logic        full, empty, push, pop;
    logic [17:0] head;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == (AW + 1)'(FIFO_DEPTH));
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign in_ready_o = !full && !reset_i;
    assign push       = in_valid_i && in_ready_o;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_x_i, in_y_i, in_colour_i};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    state_e     state_q, state_d;
    logic [7:0] base_x_q, base_x_d;
    logic [6:0] base_y_q, base_y_d;
    logic [2:0] base_colour_q, base_colour_d;
    logic [3:0] dx_q, dx_d, dy_q, dy_d;
    logic       last;

    assign last = (dx_q == LastDx) && (dy_q == LastDy);

    always_comb begin
        state_d       = state_q;
        base_x_d      = base_x_q;
        base_y_d      = base_y_q;
        base_colour_d = base_colour_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        pop           = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop           = 1'b1;
                    {base_x_d, base_y_d, base_colour_d} = head;
                    dx_d          = '0;
                    dy_d          = '0;
                    state_d       = StDraw;
                end
            end
            StDraw: begin
                if (last) begin
                    dx_d = '0;
                    dy_d = '0;
                    if (!empty) begin
                        pop = 1'b1;
                        {base_x_d, base_y_d, base_colour_d} = head;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (dx_q == LastDx) begin
                    dx_d = '0;
                    dy_d = dy_q + 4'd1;
                end else begin
                    dx_d = dx_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            base_x_q      <= '0;
            base_y_q      <= '0;
            base_colour_q <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
        end else begin
            state_q       <= state_d;
            base_x_q      <= base_x_d;
            base_y_q      <= base_y_d;
            base_colour_q <= base_colour_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
        end
    end

    // Pixel output stage; in idle dx/dy are zero so x/y settle on the base
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       clipped;
    logic [7:0] x_d;
    logic [6:0] y_d;
    logic [2:0] colour_d;
    logic       plot_d, done_d;

    always_comb begin
        sum_x    = {1'b0, base_x_q} + 9'(dx_q);
        sum_y    = {1'b0, base_y_q} + 8'(dy_q);
        clipped  = (sum_x > 9'd159) || (sum_y > 8'd119);
        x_d      = sum_x[7:0];
        y_d      = sum_y[6:0];
        colour_d = base_colour_q;
        plot_d   = (state_q == StDraw) && !clipped;
        done_d   = (state_q == StDraw) && last;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_o      <= '0;
            y_o      <= '0;
            colour_o <= '0;
            plot_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            x_o      <= x_d;
            y_o      <= y_d;
            colour_o <= colour_d;
            plot_o   <= plot_d;
            done_o   <= done_d;
        end
    end

    assign busy_o = (state_q == StDraw) || !empty;

endmodule

// File: tb/tb_box_painter.sv
// Scoreboard bench for box_painter: a timeline model predicts every visible
// pixel and done pulse with its cycle; a monitor pops and compares.
module tb_box_painter;

    localparam int W = 3;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = '0;
    logic [6:0] in_y = '0;
    logic [2:0] in_c = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    box_painter #(.BOX_W(W), .BOX_H(H), .FIFO_DEPTH(4)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_x_i     (in_x),
        .in_y_i     (in_y),
        .in_colour_i(in_c),
        .x_o        (x),
        .y_o        (y),
        .colour_o   (colour),
        .plot_o     (plot),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
        logic       d;
    } pix_t;

    pix_t sb[$];
    int   done_cycs[$];
    int   next_free = 0;
    int   errors = 0;
    int   checks = 0;
    int   pix_seen = 0;
    int   plot_cnt = 0;
    int   accepted = 0;
    bit   stall_seen = 0;
    int   acc_at_stall = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Box accepted at edge t starts 2 edges later, or right after the previous box
    task automatic model_push(input int t, input int bx, input int by, input int bc);
        int first;
        first = (t + 2 > next_free) ? t + 2 : next_free;
        next_free = first + W * H;
        for (int i = 0; i < W * H; i++) begin
            int   sx, sy;
            bit   clip, last;
            pix_t e;
            sx   = bx + i % W;
            sy   = by + i / W;
            clip = (sx > 159) || (sy > 119);
            last = (i == W * H - 1);
            if (!clip || last) begin
                e.cyc = first + i;
                e.x   = 8'(sx);
                e.y   = 7'(sy);
                e.c   = 3'(bc);
                e.p   = !clip;
                e.d   = last;
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (plot || done)) begin
            pix_t e;
            pix_seen++;
            if (plot) plot_cnt++;
            if (done) done_cycs.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pixel: got unexpected cyc=%0d x=%0d y=%0d c=%0d plot=%0b done=%0b, want none",
                         cyc, x, y, colour, plot, done);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.x != x || e.y != y || e.c != colour
                    || e.p != plot || e.d != done) begin
                    errors++;
                    $display("FAIL pixel: got cyc=%0d x=%0d y=%0d c=%0d plot=%0b done=%0b, want cyc=%0d x=%0d y=%0d c=%0d plot=%0b done=%0b",
                             cyc, x, y, colour, plot, done, e.cyc, e.x, e.y, e.c, e.p, e.d);
                end
            end
        end
    end

    // Called at a negedge; leaves in_valid high so sends can run back to back
    task automatic send(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] bc);
        bit rdy;
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        in_x     = bx;
        in_y     = by;
        in_c     = bc;
        for (int k = 0; k < 300 && !ok; k++) begin
            rdy = in_ready;
            if (!rdy && !stall_seen) begin
                stall_seen   = 1;
                acc_at_stall = accepted;
            end
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                accepted++;
                model_push(cyc, bx, by, bc);
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        int d0, pc, base, k;

        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_outputs", {x, y, colour, plot, busy, done}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);

        // Single box, then done/busy/idle-hold
        done_cycs.delete();
        send(8'd38, 7'd4, 3'b100);
        in_valid = 1'b0;
        k = 0;
        while (done_cycs.size() == 0 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("single_done_seen", done_cycs.size(), 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        @(negedge clk);
        check("idle_hold", {x, y, colour}, {8'd38, 7'd4, 3'b100});
        drain();

        // Back to back
        done_cycs.delete();
        send(8'd38, 7'd4, 3'd1);
        send(8'd43, 7'd7, 3'd2);
        drain();
        check("b2b_done_count", done_cycs.size(), 2);
        if (done_cycs.size() == 2) check("b2b_done_gap", done_cycs[1] - done_cycs[0], 9);

        // Backpressure: 1 drawing + 4 queued before the first stall
        stall_seen = 0;
        accepted   = 0;
        for (int i = 0; i < 6; i++) send(8'(10 + 5 * i), 7'(20 + i), 3'(i + 1));
        check("bp_stall_seen", stall_seen, 1);
        check("bp_accepted_at_stall", acc_at_stall, 5);
        drain();

        // Clipping at the bottom-right corner
        pc = plot_cnt;
        done_cycs.delete();
        send(8'd158, 7'd118, 3'd7);
        drain();
        check("clip_plots", plot_cnt - pc, 4);
        check("clip_done", done_cycs.size(), 1);

        // Reset on the 5th pixel with two requests queued
        base = pix_seen;
        send(8'd50, 7'd50, 3'd3);
        send(8'd60, 7'd60, 3'd4);
        send(8'd70, 7'd70, 3'd5);
        in_valid = 1'b0;
        k = 0;
        while (pix_seen < base + 5 && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("rst_mid_reached", pix_seen - base, 5);
        reset = 1'b1;
        #1;
        check("rst_mid_plot", plot, 0);
        check("rst_mid_busy_ready", {busy, in_ready}, 0);
        sb.delete();
        next_free = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pc = plot_cnt;
        @(negedge clk);
        check("rst_mid_ready", in_ready, 1);
        repeat (30) @(negedge clk);
        check("rst_mid_no_plot", plot_cnt - pc, 0);
        check("rst_mid_busy", busy, 0);

        // Randomised requests, some near the clipping edges
        for (int i = 0; i < 25; i++) begin
            send(8'($urandom_range(0, 165)), 7'($urandom_range(0, 125)), 3'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
